// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (output start, A, B, input Q, R, busy, done, dbz);
  modport slave  (input start, A, B, output Q, R, busy, done, dbz);
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional two's-complement operation when DIVIDER_SIGNED_EN is defined.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  dif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   p_shift;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fin, r_fin;

  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted value needs the extra bit for the compare.
  assign p_shift  = {rem_q, dvd_q[WIDTH-1]};
  assign ge       = (p_shift >= {1'b0, div_q});
  assign rem_next = ge ? (p_shift[WIDTH-1:0] - div_q) : p_shift[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], ge};

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign a_mag = dif.A[WIDTH-1] ? -dif.A : dif.A;
  assign b_mag = dif.B[WIDTH-1] ? -dif.B : dif.B;
  assign q_fin = qneg_q ? -quo_next : quo_next;
  assign r_fin = rneg_q ? -rem_next : rem_next;
`else
  assign a_mag = dif.A;
  assign b_mag = dif.B;
  assign q_fin = quo_next;
  assign r_fin = rem_next;
`endif

  assign accept = dif.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    a_d     = a_q;
    q_d     = q_q;
    r_d     = r_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = a_mag;
          div_d   = b_mag;
          a_d     = dif.A;
          zero_d  = (dif.B == '0);
          dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
          qneg_d  = dif.A[WIDTH-1] ^ dif.B[WIDTH-1];
          rneg_d  = dif.A[WIDTH-1];
`endif
        end
      end
      RUN: begin
        if (zero_q) begin
          state_d = FIN;
          q_d     = '1;
          r_d     = a_q;
          dbz_d   = 1'b1;
        end else begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIN;
            q_d     = q_fin;
            r_d     = r_fin;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      a_q     <= a_d;
      q_q     <= q_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign dif.Q    = q_q;
  assign dif.R    = r_q;
  assign dif.busy = (state_q == RUN);
  assign dif.done = (state_q == FIN);
  assign dif.dbz  = dbz_q;

endmodule
